simon_sequencer: RTL and testbench
==================================

# simon_sequencer

Game-core sequencer for Simon Says. It sits directly downstream of the 8-bit LFSR and samples two bits of its output whenever the sequence grows by one step. It stores the colour sequence, plays it back on one-hot LEDs with fixed on/gap timing, then checks the player's button presses against it. It reports progress (level), win and fail to the display/top-level logic.

## Interface

**Parameters**
- MAX_LEN, 16: maximum sequence length. Reaching it ends the game with a win. Range 2..64.
- STEP_TICKS, 25_000_000: number of cycles each LED is lit during playback.
- GAP_TICKS, 12_500_000: number of dark cycles after each playback step.

**Ports**
- clk, in, 1: clock.
- reset, in, 1: synchronous, active-low.
- rnd, in, 8: free-running LFSR value. Only rnd[1:0] is used; it is the colour code.
- start, in, 1: level-sampled. Begins a new game from IDLE, WIN or FAIL. Ignored in all other states.
- btn_valid, in, 1: single-cycle pulse meaning a debounced press is present.
- btn_color, in, 2: colour of the press. Qualified by btn_valid.
- led, out, 4: one-hot playback output. Colour c drives led[c].
- level, out, 7: current sequence length, 0..MAX_LEN.
- busy, out, 1: high in every state except IDLE, WIN and FAIL.
- win, out, 1: high while in WIN.
- fail, out, 1: high while in FAIL.

## Operation
- **State machine:** IDLE, APPEND, SHOW_ON, SHOW_GAP, WAIT_INPUT, WIN, FAIL.
- **Storage:** a MAX_LEN x 2-bit register array `seq`, a length register `len` (7 bits) and an index register `idx` (6 bits).
- **IDLE / WIN / FAIL:**
  - start=1 → `len`←0, go to APPEND.
  - Array contents are not cleared; they are overwritten as the sequence grows.
- **APPEND:**
  - `seq[len]`←rnd[1:0], `len`←len+1, `idx`←0.
  - Load the timer with STEP_TICKS-1, go to SHOW_ON.
- **SHOW_ON:**
  - led = onehot(seq[idx]).
  - When the timer reaches 0: load GAP_TICKS-1, go to SHOW_GAP.
- **SHOW_GAP:**
  - led = 0.
  - When the timer reaches 0 and idx==len-1: `idx`←0, go to WAIT_INPUT.
  - When the timer reaches 0 otherwise: `idx`←idx+1, load STEP_TICKS-1, go to SHOW_ON.
- **WAIT_INPUT:** on btn_valid:
  - btn_color≠seq[idx] → go to FAIL.
  - Match and idx<len-1 → `idx`←idx+1.
  - Match and idx==len-1 and len==MAX_LEN → go to WIN.
  - Match and idx==len-1 otherwise → go to APPEND.
- **btn_valid outside WAIT_INPUT:** ignored, including presses made during playback.
- **Timeout:** none; WAIT_INPUT waits indefinitely.
- **Outputs:**
  - led is decoded combinationally from state and seq[idx], with no glitch outside SHOW_ON.
  - level = len.
  - win, fail and busy are decoded from state.

## Timing
- **Reset (reset=0 at an edge):** state IDLE, len=0, idx=0, timer=0, led=0, level=0, busy=0, win=0, fail=0. Reset mid-game aborts immediately; array contents are don't-care.
- **Start latency:**
  - start sampled at edge E → APPEND after E.
  - The first LED rises after E+1 and stays on exactly STEP_TICKS cycles.
  - This is followed by exactly GAP_TICKS dark cycles.
- **Step and round latency:**
  - Each playback step is STEP_TICKS+GAP_TICKS cycles.
  - A correct final press at edge P → APPEND after P, and the next playback starts after P+1.
  - level increments at the edge leaving APPEND.
- **LFSR sampling:** rnd is sampled exactly once per round, at the APPEND edge.
- **Simultaneous events:** start together with btn_valid in WIN/FAIL → start wins and the press is ignored.
- **Timer:** a down-counter with width $clog2(max(STEP_TICKS,GAP_TICKS)). STEP_TICKS=1 or GAP_TICKS=1 must work, giving a single-cycle phase.

## Structure
- **Package `simon_pkg`:**
  - state enum `simon_state_t`
  - `color_t` (2-bit)
  - function `color_onehot(color_t)` returning 4 bits
  - localparam `NUM_COLORS=4`
- **Sub-module `tick_timer`:**
  - load/value inputs and a `done` output.
  - `done` is high when the count is 0.
  - Parameterised width.
- **Sequence array:** plain registers, not a RAM macro. It must allow an asynchronous read of seq[idx].

## Test plan
Parameters for all scenarios: MAX_LEN=3, STEP_TICKS=3, GAP_TICKS=2.

1. **Reset values:** reset low for 2 cycles, then high → led=0, level=0, busy=0, win=0, fail=0; state stays IDLE with start=0.
2. **First playback:** rnd=8'hA6 (colour 2), start pulse → level=1, led=4'b0100 for exactly 3 cycles, then 0 for 2 cycles, then WAIT_INPUT with busy=1.
3. **Correct round, second playback:** press colour 2 → APPEND. With rnd=8'h01, playback shows led 4'b0100 (3 cycles), a gap, then 4'b0010 (3 cycles), a gap; level=2.
4. **Wrong press:** with sequence {2,1}, press 2 then 3 → fail=1 on the cycle after the second press, busy=0. A later btn_valid has no effect. start → level returns to 1 and fail clears.
5. **Win:** three correct rounds with rnds giving {0,3,1} → after the last press, win=1, level=3, led=0. Presses ignored while in WIN.
6. **Abort and ignored presses:** reset asserted during SHOW_ON → all outputs 0 next cycle. btn_valid pulses during SHOW_ON/SHOW_GAP do not change idx or cause fail.

Source files
------------

// File: rtl/simon_pkg.sv
// Shared types for the Simon Says sequencer: FSM states, colour codes and the
// colour-to-LED decoder.
package simon_pkg;

    localparam int unsigned NUM_COLORS = 4;

    typedef logic [1:0] color_t;

    typedef enum logic [2:0] {
        StIdle,
        StAppend,
        StShowOn,
        StShowGap,
        StWaitInput,
        StWin,
        StFail
    } simon_state_t;

    function automatic logic [NUM_COLORS-1:0] color_onehot(color_t c);
        logic [NUM_COLORS-1:0] oh;
        oh    = '0;
        oh[c] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that parks at zero; done flags the final cycle of a phase.
module tick_timer #(
    parameter int unsigned Width = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [Width-1:0] value,
    output logic             done
);

    logic [Width-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = value;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == '0);

endmodule

// File: rtl/simon_sequencer.sv
// Simon Says game core: grows a colour sequence from the LFSR, plays it back on
// one-hot LEDs and checks the player's presses against it.
module simon_sequencer
    import simon_pkg::*;
#(
    parameter int unsigned MAX_LEN    = 16,
    parameter int unsigned STEP_TICKS = 25_000_000,
    parameter int unsigned GAP_TICKS  = 12_500_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rnd,
    input  logic       start,
    input  logic       btn_valid,
    input  logic [1:0] btn_color,
    output logic [3:0] led,
    output logic [6:0] level,
    output logic       busy,
    output logic       win,
    output logic       fail
);

    localparam int unsigned MaxTicks = (STEP_TICKS > GAP_TICKS) ? STEP_TICKS : GAP_TICKS;
    localparam int unsigned TimerW   = ($clog2(MaxTicks) < 1) ? 1 : $clog2(MaxTicks);
    localparam int unsigned IdxW     = ($clog2(MAX_LEN) < 1) ? 1 : $clog2(MAX_LEN);

    localparam logic [TimerW-1:0] StepLoad = TimerW'(STEP_TICKS - 1);
    localparam logic [TimerW-1:0] GapLoad  = TimerW'(GAP_TICKS - 1);

    simon_state_t state_d, state_q;
    logic [6:0]   len_d, len_q;
    logic [5:0]   idx_d, idx_q;
    color_t       seq_d [MAX_LEN];
    color_t       seq_q [MAX_LEN];

    logic              t_load;
    logic [TimerW-1:0] t_value;
    logic              t_done;
    color_t            cur_color;
    logic              last_step;

    tick_timer #(
        .Width(TimerW)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .load (t_load),
        .value(t_value),
        .done (t_done)
    );

    assign cur_color = seq_q[idx_q[IdxW-1:0]];
    assign last_step = ({1'b0, idx_q} == (len_q - 7'd1));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        idx_d   = idx_q;
        seq_d   = seq_q;
        t_load  = 1'b0;
        t_value = StepLoad;
        unique case (state_q)
            StIdle, StWin, StFail: begin
                // start takes priority over any simultaneous press
                if (start) begin
                    len_d   = '0;
                    state_d = StAppend;
                end
            end
            StAppend: begin
                seq_d[len_q[IdxW-1:0]] = rnd[1:0];
                len_d   = len_q + 7'd1;
                idx_d   = '0;
                t_load  = 1'b1;
                t_value = StepLoad;
                state_d = StShowOn;
            end
            StShowOn: begin
                if (t_done) begin
                    t_load  = 1'b1;
                    t_value = GapLoad;
                    state_d = StShowGap;
                end
            end
            StShowGap: begin
                if (t_done) begin
                    if (last_step) begin
                        idx_d   = '0;
                        state_d = StWaitInput;
                    end else begin
                        idx_d   = idx_q + 6'd1;
                        t_load  = 1'b1;
                        t_value = StepLoad;
                        state_d = StShowOn;
                    end
                end
            end
            StWaitInput: begin
                if (btn_valid) begin
                    if (btn_color != cur_color) begin
                        state_d = StFail;
                    end else if (!last_step) begin
                        idx_d = idx_q + 6'd1;
                    end else if (len_q == 7'(MAX_LEN)) begin
                        state_d = StWin;
                    end else begin
                        state_d = StAppend;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            len_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            idx_q   <= idx_d;
        end
    end

    // Sequence storage needs no reset: entries are rewritten before being read.
    always_ff @(posedge clk) begin
        seq_q <= seq_d;
    end

    assign led   = (state_q == StShowOn) ? color_onehot(cur_color) : 4'b0000;
    assign level = len_q;
    assign win   = (state_q == StWin);
    assign fail  = (state_q == StFail);
    assign busy  = !((state_q == StIdle) || (state_q == StWin) || (state_q == StFail));

endmodule

// File: tb/tb_simon_sequencer.sv
// Self-checking bench for simon_sequencer with a queue-based game model.
module tb_simon_sequencer;

    localparam int MAX_LEN = 3;
    localparam int STEP    = 3;
    localparam int GAP     = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rnd = 8'h00;
    logic       start = 1'b0;
    logic       btn_valid = 1'b0;
    logic [1:0] btn_color = 2'd0;
    logic [3:0] led;
    logic [6:0] level;
    logic       busy, win, fail;
    logic [13:0] obs;

    int checks   = 0;
    int failures = 0;

    int unsigned seqm[$];
    int          pos = 0;

    simon_sequencer #(
        .MAX_LEN   (MAX_LEN),
        .STEP_TICKS(STEP),
        .GAP_TICKS (GAP)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rnd      (rnd),
        .start    (start),
        .btn_valid(btn_valid),
        .btn_color(btn_color),
        .led      (led),
        .level    (level),
        .busy     (busy),
        .win      (win),
        .fail     (fail)
    );

    always #5 clk = ~clk;

    assign obs = {led, level, busy, win, fail};

    function automatic logic [13:0] mk(logic [3:0] l, int lvl, logic b, logic w, logic f);
        return {l, 7'(lvl), b, w, f};
    endfunction

    function automatic logic [3:0] oh(int unsigned c);
        return 4'b0001 << c;
    endfunction

    function automatic logic [7:0] rnd_with(int unsigned col);
        logic [7:0] r;
        r      = 8'($urandom);
        r[1:0] = 2'(col);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected LED trace: each stored colour lit STEP cycles, then GAP dark cycles.
    task automatic playback(input bit noise);
        for (int k = 0; k < seqm.size(); k++) begin
            for (int s = 0; s < STEP + GAP; s++) begin
                logic [3:0] want;
                want = (s < STEP) ? oh(seqm[k]) : 4'b0000;
                checks++;
                if (obs !== mk(want, seqm.size(), 1'b1, 1'b0, 1'b0)) begin
                    failures++;
                    $display("FAIL playback step%0d cyc%0d: actual=%b expected=%b (led,lvl,b,w,f)",
                             k, s, obs, mk(want, seqm.size(), 1'b1, 1'b0, 1'b0));
                end
                if (noise && $urandom_range(0, 2) == 0) begin
                    btn_valid = 1'b1;
                    btn_color = 2'($urandom);
                end
                tick();
                btn_valid = 1'b0;
            end
        end
        checks++;
        if (obs !== mk(4'b0000, seqm.size(), 1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL wait_entry: actual=%b expected=%b", obs,
                     mk(4'b0000, seqm.size(), 1'b1, 1'b0, 1'b0));
        end
        pos = 0;
    endtask

    // Called while the DUT sits in APPEND; rnd is only meaningful on that one edge.
    task automatic begin_round(input logic [7:0] r, input bit noise);
        rnd = r;
        tick();
        seqm.push_back(int'(r[1:0]));
        rnd = 8'($urandom);
        playback(noise);
    endtask

    task automatic start_game(input logic [7:0] r, input bit with_press, input bit noise);
        start = 1'b1;
        if (with_press) begin
            btn_valid = 1'b1;
            btn_color = 2'($urandom);
        end
        tick();
        start     = 1'b0;
        btn_valid = 1'b0;
        seqm.delete();
        checks++;
        if (obs !== mk(4'b0000, 0, 1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL start: actual=%b expected=%b", obs, mk(4'b0000, 0, 1'b1, 1'b0, 1'b0));
        end
        begin_round(r, noise);
    endtask

    // res: 0 keep waiting, 1 next round (APPEND), 2 win, 3 fail
    task automatic press(input int unsigned c, output int res);
        logic [13:0] want;
        int          n;
        n = seqm.size();
        btn_color = 2'(c);
        btn_valid = 1'b1;
        tick();
        btn_valid = 1'b0;
        if (c != seqm[pos]) begin
            res  = 3;
            want = mk(4'b0000, n, 1'b0, 1'b0, 1'b1);
        end else if (pos < n - 1) begin
            res  = 0;
            pos++;
            want = mk(4'b0000, n, 1'b1, 1'b0, 1'b0);
        end else if (n == MAX_LEN) begin
            res  = 2;
            want = mk(4'b0000, n, 1'b0, 1'b1, 1'b0);
        end else begin
            res  = 1;
            want = mk(4'b0000, n, 1'b1, 1'b0, 1'b0);
        end
        checks++;
        if (obs !== want) begin
            failures++;
            $display("FAIL press pos%0d col%0d: actual=%b expected=%b", pos, c, obs, want);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (obs !== 14'd0) begin
                failures++;
                $display("FAIL reset cyc%0d: actual=%b expected=%b", i, obs, 14'd0);
            end
        end
    endtask

    task automatic test_first_playback();
        start_game(8'hA6, 1'b0, 1'b0);
    endtask

    task automatic test_second_round();
        int res;
        press(2, res);
        begin_round(8'h01, 1'b0);
    endtask

    task automatic test_wrong_press();
        int res;
        press(2, res);
        press(3, res);
        for (int i = 0; i < 2; i++) begin
            btn_valid = 1'b1;
            btn_color = 2'($urandom);
            tick();
            btn_valid = 1'b0;
            checks++;
            if (obs !== mk(4'b0000, 2, 1'b0, 1'b0, 1'b1)) begin
                failures++;
                $display("FAIL fail_hold: actual=%b expected=%b", obs,
                         mk(4'b0000, 2, 1'b0, 1'b0, 1'b1));
            end
        end
        start_game(8'($urandom), 1'b1, 1'b0);
    endtask

    task automatic test_start_ignored();
        int res;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (obs !== mk(4'b0000, 1, 1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL start_in_wait: actual=%b expected=%b", obs,
                     mk(4'b0000, 1, 1'b1, 1'b0, 1'b0));
        end
        press((seqm[0] + 1) % 4, res);
    endtask

    task automatic test_win();
        int res;
        start_game(rnd_with(0), 1'b0, 1'b0);
        press(0, res);
        begin_round(rnd_with(3), 1'b0);
        press(0, res);
        press(3, res);
        begin_round(rnd_with(1), 1'b0);
        press(0, res);
        press(3, res);
        press(1, res);
        for (int i = 0; i < 3; i++) begin
            btn_valid = 1'b1;
            btn_color = 2'($urandom);
            tick();
            btn_valid = 1'b0;
            checks++;
            if (obs !== mk(4'b0000, 3, 1'b0, 1'b1, 1'b0)) begin
                failures++;
                $display("FAIL win_hold: actual=%b expected=%b", obs,
                         mk(4'b0000, 3, 1'b0, 1'b1, 1'b0));
            end
        end
    endtask

    task automatic test_abort();
        logic [7:0] r;
        r     = 8'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        rnd   = r;
        tick();
        checks++;
        if (obs !== mk(oh(r[1:0]), 1, 1'b1, 1'b0, 1'b0)) begin
            failures++;
            $display("FAIL abort_show: actual=%b expected=%b", obs,
                     mk(oh(r[1:0]), 1, 1'b1, 1'b0, 1'b0));
        end
        reset = 1'b0;
        tick();
        checks++;
        if (obs !== 14'd0) begin
            failures++;
            $display("FAIL abort_reset: actual=%b expected=%b", obs, 14'd0);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (obs !== 14'd0) begin
            failures++;
            $display("FAIL abort_idle: actual=%b expected=%b", obs, 14'd0);
        end
        seqm.delete();
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 8; g++) begin
            bit done;
            int res;
            start_game(8'($urandom), 1'($urandom), 1'b1);
            done = 1'b0;
            while (!done) begin
                int unsigned c;
                c = ($urandom_range(0, 11) == 0) ? (seqm[pos] + $urandom_range(1, 3)) % 4
                                                 : seqm[pos];
                press(c, res);
                if (res == 1) begin
                    begin_round(8'($urandom), 1'b1);
                end else if (res >= 2) begin
                    done = 1'b1;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_playback();
        test_second_round();
        test_wrong_press();
        test_start_ignored();
        test_win();
        test_abort();
        test_random_games();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
